// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin share of one combinational ALU between two requesters
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    output logic             req0_ready,
    output logic             req0_done,

    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             req1_ready,
    output logic             req1_done,

    output logic [WIDTH-1:0] result,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_o,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ptr;      // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic             r_idx;      // port that owns the in-flight operation
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;
    logic [WIDTH-1:0] r_result;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_alu_x;
    logic [WIDTH-1:0] r_alu_y;

    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;

    // Grants are only offered in IDLE; the pointer registered before the edge breaks ties.
    assign w_idle   = (r_state == S_IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_ptr);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid ||  r_ptr);
    assign w_accept = w_grant0 || w_grant1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b0;
            r_idx    <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_alu_op <= '0;
            r_alu_x  <= '0;
            r_alu_y  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_op <= w_grant1 ? req1_op : req0_op;
                        r_alu_x  <= w_grant1 ? req1_x  : req0_x;
                        r_alu_y  <= w_grant1 ? req1_y  : req0_y;
                        r_idx    <= w_grant1;
                        r_ptr    <= w_grant0;
                        r_busy   <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_o;
                    r_done0  <= !r_idx;
                    r_done1  <=  r_idx;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign req0_done  = r_done0;
    assign req1_done  = r_done1;
    assign busy       = r_busy;
    assign result     = r_result;
    assign alu_op     = r_alu_op;
    assign alu_x      = r_alu_x;
    assign alu_y      = r_alu_y;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter with an ALU model attached
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [OPW-1:0]   req0_op, req1_op;
    logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
    logic             req0_ready, req1_ready, req0_done, req1_done;
    logic [WIDTH-1:0] result, alu_x, alu_y, alu_o;
    logic [OPW-1:0]   alu_op;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .result     (result),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_o      (alu_o),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SLL:  return x << y[4:0];
            OP_SRL:  return x >> y[4:0];
            OP_SRA:  return 32'($signed(x) >>> y[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_o = alu_f(alu_op, alu_x, alu_y);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction timeline in absolute cycle numbers.
    int          m_cyc = 0;
    int          m_busy_end = -10;
    int          m_done_cyc = -10;
    int          m_alu_due  = -10;
    logic        m_done_port = 1'b0;
    logic        m_fav = 1'b0;
    logic [31:0] m_pend = '0, m_res = '0;
    logic [3:0]  m_op = '0, m_st_op = '0;
    logic [31:0] m_x = '0, m_y = '0, m_st_x = '0, m_st_y = '0;
    logic        m_idle, m_g0, m_g1;

    always @(negedge clk) begin
        if (!reset) begin
            check("rst ready0", 32'(req0_ready), 32'd0);
            check("rst ready1", 32'(req1_ready), 32'd0);
            check("rst done0",  32'(req0_done),  32'd0);
            check("rst done1",  32'(req1_done),  32'd0);
            check("rst busy",   32'(busy),       32'd0);
            check("rst result", result, 32'd0);
            check("rst alu_op", 32'(alu_op), 32'd0);
            check("rst alu_x",  alu_x, 32'd0);
            check("rst alu_y",  alu_y, 32'd0);
            m_cyc = 0; m_busy_end = -10; m_done_cyc = -10; m_alu_due = -10;
            m_fav = 1'b0; m_res = '0; m_op = '0; m_x = '0; m_y = '0;
        end else begin
            m_idle = (m_cyc > m_busy_end);
            if (m_cyc == m_alu_due) begin
                m_op = m_st_op; m_x = m_st_x; m_y = m_st_y;
            end
            if (m_cyc == m_done_cyc) m_res = m_pend;
            m_g0 = 1'b0;
            m_g1 = 1'b0;
            if (m_idle) begin
                if (req0_valid && req1_valid) begin
                    m_g0 = !m_fav;
                    m_g1 = m_fav;
                end else begin
                    m_g0 = req0_valid;
                    m_g1 = req1_valid;
                end
            end
            check("ready0", 32'(req0_ready), 32'(m_g0));
            check("ready1", 32'(req1_ready), 32'(m_g1));
            check("done0",  32'(req0_done), 32'(m_cyc == m_done_cyc && m_done_port == 1'b0));
            check("done1",  32'(req1_done), 32'(m_cyc == m_done_cyc && m_done_port == 1'b1));
            check("busy",   32'(busy), 32'(!m_idle));
            check("result", result, m_res);
            check("alu_op", 32'(alu_op), 32'(m_op));
            check("alu_x",  alu_x, m_x);
            check("alu_y",  alu_y, m_y);
            if (m_g0 || m_g1) begin
                m_done_port = m_g1;
                m_busy_end  = m_cyc + 2;
                m_done_cyc  = m_cyc + 2;
                m_alu_due   = m_cyc + 1;
                m_st_op     = m_g1 ? req1_op : req0_op;
                m_st_x      = m_g1 ? req1_x  : req0_x;
                m_st_y      = m_g1 ? req1_y  : req0_y;
                m_pend      = alu_f(m_st_op, m_st_x, m_st_y);
                m_fav       = !m_g1;
            end
            m_cyc++;
        end
    end

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = '0; req0_x = '0; req0_y = '0;
        req1_valid = 1'b0; req1_op = '0; req1_x = '0; req1_y = '0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Issue one operation on a single port, scrub the operands after accept, check the result.
    task automatic run_vec(input vec_t v, input int idx);
        bit got;
        got = 1'b0;
        if (v.port) begin
            req1_valid = 1'b1; req1_op = v.op; req1_x = v.x; req1_y = v.y;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_x = v.x; req0_y = v.y;
        end
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (v.port ? req1_ready : req0_ready) got = 1'b1;
            step();
        end
        idle_inputs();
        if (!got) begin
            check($sformatf("vec%0d accept timeout", idx), 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            step();
            @(negedge clk);
            check($sformatf("vec%0d done", idx), 32'(v.port ? req1_done : req0_done), 32'd1);
            check($sformatf("vec%0d other done", idx), 32'(v.port ? req0_done : req1_done), 32'd0);
            check($sformatf("vec%0d result", idx), result, v.exp);
            step();
        end
    endtask

    int   acc_cyc[$];
    logic acc_port[$];
    logic s0, s1;

    initial begin
        vecs[0] = '{1'b0, OP_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
        vecs[1] = '{1'b1, OP_SRA, 32'h8000_0000, 32'd33,        32'hC000_0000};
        vecs[2] = '{1'b0, OP_SUB, 32'd10,        32'd3,         32'h0000_0007};
        vecs[3] = '{1'b1, OP_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0};
        vecs[4] = '{1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{1'b1, OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, OP_SLL, 32'h0000_0001, 32'd31,        32'h8000_0000};
        vecs[7] = '{1'b1, OP_SRL, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[8] = '{1'b0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[9] = '{1'b1, OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F};

        reset = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Both requesters held for six operations: grants alternate, accepts 3 cycles apart.
        do_reset();
        req0_valid = 1'b1; req0_op = OP_SUB; req0_x = 32'd10;  req0_y = 32'd3;
        req1_valid = 1'b1; req1_op = OP_XOR; req1_x = 32'hFF;  req1_y = 32'h0F;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (req0_ready) begin acc_cyc.push_back(c); acc_port.push_back(1'b0); end
            if (req1_ready) begin acc_cyc.push_back(c); acc_port.push_back(1'b1); end
            if (req0_done) check("both done0 result", result, 32'd7);
            if (req1_done) check("both done1 result", result, 32'hF0);
            step();
        end
        idle_inputs();
        check("both accept count", 32'(acc_cyc.size()), 32'd6);
        for (int i = 0; i < acc_cyc.size() && i < 6; i++) begin
            check($sformatf("both grant%0d port", i), 32'(acc_port[i]), 32'(i % 2));
            check($sformatf("both grant%0d cycle", i), 32'(acc_cyc[i]), 32'(3 * i));
        end

        // Async reset during EXEC aborts the operation.
        step();
        req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 32'd1; req0_y = 32'd1;
        @(negedge clk);
        check("abort accept", 32'(req0_ready), 32'd1);
        step();
        idle_inputs();
        check("abort in exec alu_x", alu_x, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async rst alu_x", alu_x, 32'd0);
        check("async rst alu_op", 32'(alu_op), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done0", 32'(req0_done), 32'd0);
        check("async rst result", result, 32'd0);
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post abort done0", 32'(req0_done), 32'd0);
            step();
        end
        req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 32'd2; req0_y = 32'd2;
        req1_valid = 1'b1; req1_op = OP_ADD; req1_x = 32'd4; req1_y = 32'd4;
        @(negedge clk);
        check("post reset favours port0", 32'({req1_ready, req0_ready}), 32'b01);
        step();
        idle_inputs();
        step(); step();

        // req0 pulsed while busy and withdrawn before IDLE.
        req1_valid = 1'b1; req1_op = OP_ADD; req1_x = 32'd20; req1_y = 32'd22;
        @(negedge clk);
        step();
        idle_inputs();
        req0_valid = 1'b1; req0_op = OP_SUB; req0_x = 32'd99; req0_y = 32'd1;
        @(negedge clk);
        check("busy pulse ready0", 32'(req0_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("withdrawn done0", 32'(req0_done), 32'd0);
            check("withdrawn result", result, 32'd42);
            step();
        end
        req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 32'd0; req0_y = 32'd0;
        req1_valid = 1'b1; req1_op = OP_ADD; req1_x = 32'd0; req1_y = 32'd0;
        @(negedge clk);
        check("withdrawn ptr unchanged", 32'({req1_ready, req0_ready}), 32'b01);
        step();
        idle_inputs();
        step(); step();

        // Randomised traffic under the requester contract.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            s0 = req0_ready;
            s1 = req1_ready;
            step();
            if (req0_valid && !s0) begin
                if ($urandom_range(9) == 0) req0_valid = 1'b0;
            end else begin
                req0_valid = ($urandom_range(2) != 0);
                req0_op    = 4'($urandom_range(7));
                req0_x     = $urandom;
                req0_y     = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            end
            if (req1_valid && !s1) begin
                if ($urandom_range(9) == 0) req1_valid = 1'b0;
            end else begin
                req1_valid = ($urandom_range(2) != 0);
                req1_op    = 4'($urandom_range(7));
                req1_x     = $urandom;
                req1_y     = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            end
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: the execute stage (port 0) and the address/branch-compare unit (port 1).
- Arbitrates round-robin, registers the winning operands onto the ALU inputs and captures the ALU output.
- Returns the result with a one-cycle done pulse to the winner.
- Sits between the CPU control FSM and the ALU instance; the ALU itself is unchanged.

Parameters:
WIDTH, 32, operand/result width (matches ALU X/Y/O)
OPW, 4, ALU operation code width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has an operation pending
req0_op  input  OPW  requester 0 ALU operation code
req0_x  input  WIDTH  requester 0 operand X
req0_y  input  WIDTH  requester 0 operand Y
req0_ready  output  1  requester 0 accepted this cycle
req0_done  output  1  one-cycle pulse: result valid for requester 0
req1_valid  input  1  as req0, for requester 1
req1_op  input  OPW  as req0
req1_x  input  WIDTH  as req0
req1_y  input  WIDTH  as req0
req1_ready  output  1  as req0
req1_done  output  1  as req0
result  output  WIDTH  registered ALU result, held until the next capture
alu_op  output  OPW  to ALU operation
alu_x  output  WIDTH  to ALU X
alu_y  output  WIDTH  to ALU Y
alu_o  input  WIDTH  from ALU O
busy  output  1  high in EXEC and DONE

Behaviour:
- Reset (reset=0, async): state=IDLE, pointer=0 (port 0 favoured). alu_op, alu_x, alu_y, result = 0; all ready/done = 0; busy=0.
- States:
  - IDLE: grant computed combinationally.
    - If only one valid: that port is granted.
    - If both valid: the port the pointer favours is granted.
    - reqN_ready = grant, asserted only in IDLE, combinational from valid and pointer.
    - On a clock edge with a grant: latch reqN_op/x/y into alu_op/alu_x/alu_y, record the granted index, set pointer to favour the other port, go to EXEC.
    - No valid: stay in IDLE; outputs hold.
  - EXEC: ALU settles on the registered inputs. On the next edge, result <= alu_o; go to DONE.
  - DONE: reqN_done=1 for the recorded index only; next edge goes to IDLE. The other done stays 0.
- Latency: accept edge -> done visible 2 cycles later. Throughput: 1 operation per 3 cycles.
- Pointer updates only on an accept. With a single active requester, that requester is granted every IDLE cycle.
- Requester contract: hold op/x/y stable while valid and not ready. Dropping valid before ready is legal; no operation is issued and the pointer is unchanged.
- Operands are captured at accept. Requester input changes after accept do not affect the issued operation.
- ready is never asserted in EXEC or DONE. A valid raised during busy waits for IDLE.
- result and alu_* hold their values through IDLE until the next accept/capture. No X propagation.
- Op codes pass through unmodified. Semantics and width rules (shift amount = Y[4:0], wrap-around add/sub) belong to the ALU.
- Reset asserted mid-operation (EXEC or DONE): immediate return to reset values. No done pulse is issued for the aborted operation. The requester must re-request.
- Both valid on the same cycle the pointer changes: the pointer value registered before the edge decides the grant.

Test Plan:
1. Port 0 only, op=ADD, X=0x00000005, Y=0x00000003 -> req0_ready at cycle 0; req0_done=1 and result=0x00000008 at cycle 2; req1_done stays 0.
2. Both valid after reset, req0 op=SUB X=10 Y=3, req1 op=XOR X=0xFF Y=0x0F -> port 0 first (done, result=7), port 1 next (done 3 cycles later, result=0xF0). Pointer alternates.
3. Both held valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1. Each done pulse lasts exactly 1 cycle. Accepts are spaced 3 cycles apart.
4. req1 only, op=ShiftRightSigned, X=0x80000000, Y=33 -> result=0xC0000000 (ALU uses Y mod 32). Operands changed to 0 the cycle after accept -> result unchanged.
5. reset asserted during EXEC of X=1, Y=1 ADD -> all outputs 0 asynchronously, no done. After release, state=IDLE and pointer favours port 0.
6. req0_valid pulsed high while busy, then dropped before IDLE -> no ready, no done, result unchanged, pointer unchanged.
